// File: rtl/shadow_pkg.sv
// Shared definitions for the 16-bit two-branch Shadow cipher datapath.
// Both the encryption and decryption cores take their branch function from here.
package shadow_pkg;

  localparam int ROUNDS_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // f(x) = (rol(x,1) & rol(x,7)) ^ rol(x,2); rol by 7 is a right rotate by 1.
  function automatic logic [7:0] shadow_f(input logic [7:0] x);
    logic [7:0] rl1;
    logic [7:0] rl7;
    logic [7:0] rl2;
    rl1 = {x[6:0], x[7]};
    rl7 = {x[0], x[7:1]};
    rl2 = {x[5:0], x[7:6]};
    return (rl1 & rl7) ^ rl2;
  endfunction

endpackage

// File: rtl/shadow_round_inv.sv
// One inverse Shadow round: recovers (L_i, R_i) from (L_{i+1}, R_{i+1}) and k_i.
module shadow_round_inv
  import shadow_pkg::*;
(
  input  logic [7:0] l_in,
  input  logic [7:0] r_in,
  input  logic [7:0] k,
  output logic [7:0] l_out,
  output logic [7:0] r_out
);

  assign l_out = r_in;
  assign r_out = l_in ^ shadow_f(r_in) ^ k;

endmodule

// File: rtl/shadow_dec16.sv
// Iterative Shadow decryption core: one inverse round per clock, round keys
// consumed from an internal key file in reverse order, valid/ready on both sides.
module shadow_dec16
  import shadow_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEF,
  localparam int AW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_we,
  input  logic [AW-1:0] key_addr,
  input  logic [7:0]    key_in,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    ct_l,
  input  logic [7:0]    ct_r,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    pt_l,
  output logic [7:0]    pt_r
);

  state_t     state;
  logic [7:0] cnt;
  logic [7:0] l_p0;
  logic [7:0] r_p0;
  logic [7:0] key_mem [ROUNDS];
  logic [7:0] rk;
  logic [7:0] l_nxt;
  logic [7:0] r_nxt;

  // Round-key select by the counter; cnt never exceeds ROUNDS-1 while running.
  always_comb begin
    rk = 8'h00;
    for (int i = 0; i < ROUNDS; i++) begin
      if (cnt == 8'(i)) rk = key_mem[i];
    end
  end

  shadow_round_inv u_round (
    .l_in  (l_p0),
    .r_in  (r_p0),
    .k     (rk),
    .l_out (l_nxt),
    .r_out (r_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'h00;
      l_p0  <= 8'h00;
      r_p0  <= 8'h00;
      for (int i = 0; i < ROUNDS; i++) key_mem[i] <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          // Addresses outside the file match no entry and are dropped.
          if (key_we) begin
            for (int i = 0; i < ROUNDS; i++) begin
              if (key_addr == AW'(i)) key_mem[i] <= key_in;
            end
          end
          if (in_valid) begin
            l_p0  <= ct_l;
            r_p0  <= ct_r;
            cnt   <= 8'(ROUNDS - 1);
            state <= RUN;
          end
        end
        RUN: begin
          l_p0 <= l_nxt;
          r_p0 <= r_nxt;
          if (cnt == 8'h00) state <= DONE;
          else cnt <= cnt - 8'h01;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign pt_l      = l_p0;
  assign pt_r      = r_p0;

endmodule

// File: tb/tb_shadow_dec16.sv
// Bench for shadow_dec16: a 16-round and a 1-round instance checked against a
// forward-cipher reference model.
module tb_shadow_dec16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 16-round instance
  logic       rst16 = 1'b1, key_we16 = 1'b0, in_valid16 = 1'b0, out_ready16 = 1'b0;
  logic [3:0] key_addr16 = '0;
  logic [7:0] key_in16 = '0, ct_l16 = '0, ct_r16 = '0;
  logic       in_ready16, out_valid16;
  logic [7:0] pt_l16, pt_r16;

  // 1-round instance
  logic       rst1 = 1'b1, key_we1 = 1'b0, in_valid1 = 1'b0, out_ready1 = 1'b0;
  logic [0:0] key_addr1 = '0;
  logic [7:0] key_in1 = '0, ct_l1 = '0, ct_r1 = '0;
  logic       in_ready1, out_valid1;
  logic [7:0] pt_l1, pt_r1;

  shadow_dec16 #(.ROUNDS(16)) u_dut16 (
    .clk(clk), .rst(rst16), .key_we(key_we16), .key_addr(key_addr16), .key_in(key_in16),
    .in_valid(in_valid16), .in_ready(in_ready16), .ct_l(ct_l16), .ct_r(ct_r16),
    .out_valid(out_valid16), .out_ready(out_ready16), .pt_l(pt_l16), .pt_r(pt_r16)
  );

  shadow_dec16 #(.ROUNDS(1)) u_dut1 (
    .clk(clk), .rst(rst1), .key_we(key_we1), .key_addr(key_addr1), .key_in(key_in1),
    .in_valid(in_valid1), .in_ready(in_ready1), .ct_l(ct_l1), .ct_r(ct_r1),
    .out_valid(out_valid1), .out_ready(out_ready1), .pt_l(pt_l1), .pt_r(pt_r1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] mk [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rol(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] f_ref(input logic [7:0] x);
    return (rol(x, 1) & rol(x, 7)) ^ rol(x, 2);
  endfunction

  // Forward cipher over the model key array: returns {L_16, R_16}.
  function automatic logic [15:0] encrypt(input logic [7:0] l0, input logic [7:0] r0);
    logic [7:0] l, r, t;
    l = l0;
    r = r0;
    for (int i = 0; i < 16; i++) begin
      t = r ^ f_ref(l) ^ mk[i];
      r = l;
      l = t;
    end
    return {l, r};
  endfunction

  task automatic wr16(input logic [3:0] a, input logic [7:0] d);
    key_we16 = 1'b1; key_addr16 = a; key_in16 = d;
    @(posedge clk); #1;
    key_we16 = 1'b0;
  endtask

  task automatic dec16(input logic [7:0] cl, input logic [7:0] cr,
                       output logic [7:0] pl, output logic [7:0] pr, output int lat);
    check("in_ready_before_accept", 32'(in_ready16), 32'd1);
    in_valid16 = 1'b1; ct_l16 = cl; ct_r16 = cr;
    @(posedge clk); #1;
    in_valid16 = 1'b0; key_we16 = 1'b0;
    lat = 0;
    while (!out_valid16 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    pl = pt_l16; pr = pt_r16;
    out_ready16 = 1'b1;
    @(posedge clk); #1;
    out_ready16 = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] pl, pr, l0, r0, hl, hr;
    logic [15:0] ct;
    int lat;

    repeat (2) @(posedge clk);
    #1;
    rst16 = 1'b0; rst1 = 1'b0;

    check("rst_in_ready",  32'(in_ready16),  32'd1);
    check("rst_out_valid", 32'(out_valid16), 32'd0);
    check("rst_pt_l",      32'(pt_l16),      32'h00);
    check("rst_pt_r",      32'(pt_r16),      32'h00);
    check("rst1_in_ready", 32'(in_ready1),   32'd1);

    // All-zero keys, zero ciphertext
    for (int i = 0; i < 16; i++) mk[i] = 8'h00;
    dec16(8'h00, 8'h00, pl, pr, lat);
    check("zero_pt_l", 32'(pl), 32'h00);
    check("zero_pt_r", 32'(pr), 32'h00);
    check("zero_latency", 32'(lat), 32'd16);
    check("idle_after_drain", 32'(in_ready16), 32'd1);
    check("no_valid_after_drain", 32'(out_valid16), 32'd0);

    // Single-round instance: out-of-range key write must be dropped
    key_we1 = 1'b1; key_addr1 = 1'b0; key_in1 = 8'h00; @(posedge clk); #1;
    key_addr1 = 1'b1; key_in1 = 8'hFF; @(posedge clk); #1;
    key_we1 = 1'b0;
    in_valid1 = 1'b1; ct_l1 = 8'h00; ct_r1 = 8'h01; @(posedge clk); #1;
    in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 20) begin @(posedge clk); #1; lat++; end
    check("r1_latency", 32'(lat), 32'd1);
    check("r1_k00_pt_l", 32'(pt_l1), 32'h01);
    check("r1_k00_pt_r", 32'(pt_r1), 32'h04);
    out_ready1 = 1'b1; @(posedge clk); #1; out_ready1 = 1'b0;
    // Key write in the same cycle as accept lands before the round uses it
    key_we1 = 1'b1; key_addr1 = 1'b0; key_in1 = 8'h5A;
    in_valid1 = 1'b1; @(posedge clk); #1;
    in_valid1 = 1'b0; key_we1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 20) begin @(posedge clk); #1; lat++; end
    check("r1_k5a_pt_l", 32'(pt_l1), 32'h01);
    check("r1_k5a_pt_r", 32'(pt_r1), 32'h5E);
    out_ready1 = 1'b1; @(posedge clk); #1; out_ready1 = 1'b0;

    // Random key sets and plaintexts; last key written together with accept
    for (int b = 0; b < 1000; b++) begin
      for (int i = 0; i < 16; i++) mk[i] = 8'($urandom);
      for (int i = 0; i < 15; i++) wr16(4'(i), mk[i]);
      key_we16 = 1'b1; key_addr16 = 4'd15; key_in16 = mk[15];
      l0 = 8'($urandom); r0 = 8'($urandom);
      ct = encrypt(l0, r0);
      dec16(ct[15:8], ct[7:0], pl, pr, lat);
      check("rand_pt_l", 32'(pl), 32'(l0));
      check("rand_pt_r", 32'(pr), 32'(r0));
      check("rand_latency", 32'(lat), 32'd16);
    end

    // Backpressure in DONE; keys remain from the last random set
    l0 = 8'hC3; r0 = 8'h3C;
    ct = encrypt(l0, r0);
    in_valid16 = 1'b1; ct_l16 = ct[15:8]; ct_r16 = ct[7:0];
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    lat = 0;
    while (!out_valid16 && lat < 200) begin @(posedge clk); #1; lat++; end
    check("bp_latency", 32'(lat), 32'd16);
    hl = pt_l16; hr = pt_r16;
    check("bp_pt_l", 32'(hl), 32'(l0));
    check("bp_pt_r", 32'(hr), 32'(r0));
    for (int c = 0; c < 10; c++) begin
      in_valid16 = 1'($urandom_range(0, 1));
      ct_l16 = 8'($urandom); ct_r16 = 8'($urandom);
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid16), 32'd1);
      check("bp_in_ready",  32'(in_ready16),  32'd0);
      check("bp_hold_l",    32'(pt_l16),      32'(hl));
      check("bp_hold_r",    32'(pt_r16),      32'(hr));
    end
    in_valid16 = 1'b0; out_ready16 = 1'b1;
    @(posedge clk); #1;
    out_ready16 = 1'b0;
    check("bp_release_valid", 32'(out_valid16), 32'd0);
    check("bp_release_ready", 32'(in_ready16),  32'd1);
    @(posedge clk); #1;
    check("bp_single_transfer", 32'(out_valid16), 32'd0);

    // key_we during RUN and DONE must not disturb the key file
    for (int i = 0; i < 16; i++) begin mk[i] = 8'($urandom); wr16(4'(i), mk[i]); end
    l0 = 8'h12; r0 = 8'h34;
    ct = encrypt(l0, r0);
    in_valid16 = 1'b1; ct_l16 = ct[15:8]; ct_r16 = ct[7:0];
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    key_we16 = 1'b1; key_in16 = 8'hFF;
    lat = 0;
    while (!out_valid16 && lat < 200) begin
      key_addr16 = 4'(lat);
      @(posedge clk); #1;
      lat++;
    end
    @(posedge clk); #1;
    key_we16 = 1'b0;
    check("kwrun_pt_l", 32'(pt_l16), 32'(l0));
    check("kwrun_pt_r", 32'(pt_r16), 32'(r0));
    out_ready16 = 1'b1; @(posedge clk); #1; out_ready16 = 1'b0;
    l0 = 8'hA5; r0 = 8'h5A;
    ct = encrypt(l0, r0);
    dec16(ct[15:8], ct[7:0], pl, pr, lat);
    check("kwrun_next_pt_l", 32'(pl), 32'(l0));
    check("kwrun_next_pt_r", 32'(pr), 32'(r0));

    // Reset mid-RUN aborts and clears the key file
    in_valid16 = 1'b1; ct_l16 = 8'h77; ct_r16 = 8'h99;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst16 = 1'b1;
    @(posedge clk); #1;
    rst16 = 1'b0;
    check("midrst_in_ready",  32'(in_ready16),  32'd1);
    check("midrst_out_valid", 32'(out_valid16), 32'd0);
    check("midrst_pt_l",      32'(pt_l16),      32'h00);
    check("midrst_pt_r",      32'(pt_r16),      32'h00);
    for (int i = 0; i < 16; i++) mk[i] = 8'h00;
    l0 = 8'h6D; r0 = 8'hE1;
    ct = encrypt(l0, r0);
    dec16(ct[15:8], ct[7:0], pl, pr, lat);
    check("midrst_zero_key_pt_l", 32'(pl), 32'(l0));
    check("midrst_zero_key_pt_r", 32'(pr), 32'(r0));
    check("midrst_latency", 32'(lat), 32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
